// File: rtl/weight_seq_ctrl.sv
// weight_seq_ctrl: walks the shared 19x128b weight memory through eight
// layers, offering one column per valid/ready beat with a per-layer ack.
module weight_seq_ctrl #(
  parameter int ADDR_W    = 5,
  parameter int N_LAYERS  = 8,
  parameter int LAST_ADDR = 18
) (
  input  logic              Clock,
  input  logic              Res,
  input  logic              Start,
  input  logic              Load_w,
  input  logic              Abort,
  input  logic              W_ready,
  input  logic              Layer_ack,
  output logic              En_w_mem,
  output logic [ADDR_W-1:0] Addr_mem_w,
  output logic              W_valid,
  output logic [2:0]        Layer_idx,
  output logic [1:0]        Col_idx,
  output logic              Layer_end,
  output logic              Busy,
  output logic              Done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_LWAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] LAST_L = 3'(N_LAYERS - 1);

  state_t state;

  // Base address of each layer; L8 ends on the final memory word.
  function automatic logic [ADDR_W-1:0] base_of(input logic [2:0] l);
    case (l)
      3'd0:    base_of = ADDR_W'(0);
      3'd1:    base_of = ADDR_W'(4);
      3'd2:    base_of = ADDR_W'(6);
      3'd3:    base_of = ADDR_W'(7);
      3'd4:    base_of = ADDR_W'(8);
      3'd5:    base_of = ADDR_W'(9);
      3'd6:    base_of = ADDR_W'(11);
      default: base_of = ADDR_W'(LAST_ADDR - 3);
    endcase
  endfunction

  function automatic logic [1:0] last_col(input logic [2:0] l);
    case (l)
      3'd0:    last_col = 2'd3;
      3'd1:    last_col = 2'd1;
      3'd2:    last_col = 2'd0;
      3'd3:    last_col = 2'd0;
      3'd4:    last_col = 2'd0;
      3'd5:    last_col = 2'd1;
      3'd6:    last_col = 2'd3;
      default: last_col = 2'd3;
    endcase
  endfunction

  always_ff @(posedge Clock) begin
    if (Res || (Abort && state != S_IDLE)) begin
      state      <= S_IDLE;
      En_w_mem   <= 1'b0;
      Addr_mem_w <= '0;
      W_valid    <= 1'b0;
      Layer_idx  <= '0;
      Col_idx    <= '0;
      Layer_end  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      En_w_mem <= 1'b0;
      Done     <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (Start && Load_w) begin
            state    <= S_LOAD;
            En_w_mem <= 1'b1;
            Busy     <= 1'b1;
          end else if (Start) begin
            state      <= S_RUN;
            W_valid    <= 1'b1;
            Busy       <= 1'b1;
            Layer_idx  <= '0;
            Col_idx    <= '0;
            Addr_mem_w <= base_of(3'd0);
            Layer_end  <= (last_col(3'd0) == 2'd0);
          end
        end
        S_LOAD: begin
          state      <= S_RUN;
          W_valid    <= 1'b1;
          Layer_idx  <= '0;
          Col_idx    <= '0;
          Addr_mem_w <= base_of(3'd0);
          Layer_end  <= (last_col(3'd0) == 2'd0);
        end
        S_RUN: begin
          if (W_ready) begin
            if (Layer_end) begin
              state     <= S_LWAIT;
              W_valid   <= 1'b0;
              Layer_end <= 1'b0;
            end else begin
              Col_idx    <= Col_idx + 2'd1;
              Addr_mem_w <= Addr_mem_w + ADDR_W'(1);
              Layer_end  <= ((Col_idx + 2'd1) == last_col(Layer_idx));
            end
          end
        end
        S_LWAIT: begin
          if (Layer_ack) begin
            if (Layer_idx == LAST_L) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state      <= S_RUN;
              W_valid    <= 1'b1;
              Layer_idx  <= Layer_idx + 3'd1;
              Col_idx    <= '0;
              Addr_mem_w <= base_of(Layer_idx + 3'd1);
              Layer_end  <= (last_col(Layer_idx + 3'd1) == 2'd0);
            end
          end
        end
        S_DONE: begin
          state      <= S_IDLE;
          Busy       <= 1'b0;
          Layer_idx  <= '0;
          Col_idx    <= '0;
          Addr_mem_w <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_seq_ctrl.sv
// tb_weight_seq_ctrl: scoreboard bench; beats predicted from the layer
// column counts, popped by a monitor on every handshake.
module tb_weight_seq_ctrl;

  logic       Clock = 1'b0;
  logic       Res = 1'b1;
  logic       Start = 1'b0;
  logic       Load_w = 1'b0;
  logic       Abort = 1'b0;
  logic       W_ready = 1'b0;
  logic       Layer_ack = 1'b0;
  logic       En_w_mem;
  logic [4:0] Addr_mem_w;
  logic       W_valid;
  logic [2:0] Layer_idx;
  logic [1:0] Col_idx;
  logic       Layer_end;
  logic       Busy;
  logic       Done;

  weight_seq_ctrl dut (
    .Clock(Clock), .Res(Res), .Start(Start), .Load_w(Load_w),
    .Abort(Abort), .W_ready(W_ready), .Layer_ack(Layer_ack),
    .En_w_mem(En_w_mem), .Addr_mem_w(Addr_mem_w), .W_valid(W_valid),
    .Layer_idx(Layer_idx), .Col_idx(Col_idx), .Layer_end(Layer_end),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int addr;
    int layer;
    int col;
    int last;
  } beat_t;

  beat_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int en_cnt = 0;
  int en_cyc = -1;
  int done_cnt = 0;
  int n_beats = 0;

  always @(posedge Clock) cyc++;

  // Monitor: every accepted beat must be the next predicted one.
  always @(negedge Clock) begin
    if (!Res) begin
      if (En_w_mem) begin
        en_cnt++;
        en_cyc = cyc;
      end
      if (Done) done_cnt++;
      if (W_valid && W_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL beat_unexpected got addr=%0d want none", Addr_mem_w);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (int'(Addr_mem_w) != e.addr || int'(Layer_idx) != e.layer ||
              int'(Col_idx) != e.col || int'(Layer_end) != e.last) begin
            bad++;
            $display("FAIL beat got a=%0d l=%0d c=%0d e=%0d want a=%0d l=%0d c=%0d e=%0d",
                     Addr_mem_w, Layer_idx, Col_idx, Layer_end,
                     e.addr, e.layer, e.col, e.last);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Reference: layers are packed back to back with these column counts.
  function automatic int build_pass();
    int cols[8] = '{4, 2, 1, 1, 1, 2, 4, 4};
    int a = 0;
    for (int l = 0; l < 8; l++)
      for (int c = 0; c < cols[l]; c++) begin
        exp_q.push_back('{a, l, c, (c == cols[l] - 1) ? 1 : 0});
        a++;
      end
    return a;
  endfunction

  task automatic start_pass(input bit ld);
    step();
    Start = 1'b1;
    Load_w = ld;
    t0 = cyc;
    n_beats = build_pass();
    step();
    Start = 1'b0;
    Load_w = 1'b0;
  endtask

  task automatic wait_addr(input int a);
    for (int i = 0; i < 100; i++) begin
      if (W_valid && int'(Addr_mem_w) == a) return;
      step();
    end
    chk("wait_addr_timeout", -1, a);
  endtask

  task automatic run_done(input int budget, input bit rnd, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      if (Done) begin
        dc = cyc;
        break;
      end
      if (rnd) begin
        W_ready = 1'($urandom_range(0, 1));
        Layer_ack = 1'($urandom_range(0, 1));
      end
      step();
    end
    if (dc < 0) chk("done_timeout", dc, 0);
    W_ready = 1'b1;
    Layer_ack = 1'b1;
  endtask

  initial begin
    int dc;
    int dsnap;
    int lat;
    Res = 1'b1;
    repeat (3) step();
    chk("rst_busy", Busy, 0);
    chk("rst_valid", W_valid, 0);
    chk("rst_addr", Addr_mem_w, 0);
    chk("rst_en", En_w_mem, 0);
    chk("rst_done", Done, 0);
    chk("rst_layer", Layer_idx, 0);
    Res = 1'b0;
    W_ready = 1'b1;
    Layer_ack = 1'b1;

    // Full pass with load; unstalled latency = load + beats + acks + 1.
    en_cnt = 0;
    done_cnt = 0;
    start_pass(1'b1);
    lat = 1 + n_beats + 8 + 1;
    run_done(80, 1'b0, dc);
    chk("t1_done_cycle", dc - t0, lat);
    chk("t1_en_count", en_cnt, 1);
    chk("t1_en_cycle", en_cyc - t0, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    step();
    chk("t1_done_pulse", Done, 0);
    chk("t1_busy_after", Busy, 0);
    chk("t1_done_count", done_cnt, 1);

    // Pass without load.
    en_cnt = 0;
    start_pass(1'b0);
    lat = n_beats + 8 + 1;
    chk("t6_valid_c1", W_valid, 1);
    chk("t6_addr_c1", Addr_mem_w, 0);
    chk("t6_en_c1", En_w_mem, 0);
    chk("t6_busy_c1", Busy, 1);
    run_done(80, 1'b0, dc);
    chk("t6_done_cycle", dc - t0, lat);
    chk("t6_en_count", en_cnt, 0);

    // Stall at address 2.
    start_pass(1'b0);
    wait_addr(2);
    W_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t2_stall_addr", Addr_mem_w, 2);
      chk("t2_stall_valid", W_valid, 1);
      chk("t2_stall_col", Col_idx, 2);
    end
    W_ready = 1'b1;
    step();
    chk("t2_resume_addr", Addr_mem_w, 3);
    chk("t2_resume_end", Layer_end, 1);
    run_done(80, 1'b0, dc);
    chk("t2_queue_empty", exp_q.size(), 0);

    // Late layer ack after L2.
    start_pass(1'b0);
    wait_addr(5);
    Layer_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_wait_valid", W_valid, 0);
      chk("t3_wait_addr", Addr_mem_w, 5);
      if (i == 4) Layer_ack = 1'b1;
    end
    step();
    chk("t3_next_addr", Addr_mem_w, 6);
    chk("t3_next_layer", Layer_idx, 2);
    chk("t3_next_valid", W_valid, 1);
    run_done(80, 1'b0, dc);

    // Abort beats a simultaneous handshake and Start.
    start_pass(1'b0);
    wait_addr(12);
    dsnap = done_cnt;
    Abort = 1'b1;
    Start = 1'b1;
    step();
    Abort = 1'b0;
    Start = 1'b0;
    exp_q.delete();
    chk("t4_busy", Busy, 0);
    chk("t4_addr", Addr_mem_w, 0);
    chk("t4_valid", W_valid, 0);
    chk("t4_col", Col_idx, 0);
    chk("t4_layer", Layer_idx, 0);
    repeat (3) step();
    chk("t4_no_done", done_cnt, dsnap);
    chk("t4_stay_idle", Busy, 0);
    start_pass(1'b0);
    chk("t4_restart_addr", Addr_mem_w, 0);
    chk("t4_restart_valid", W_valid, 1);
    run_done(80, 1'b0, dc);

    // Reset mid-run; a stray Start earlier in the pass is ignored.
    start_pass(1'b0);
    wait_addr(4);
    Start = 1'b1;
    step();
    Start = 1'b0;
    wait_addr(9);
    dsnap = done_cnt;
    Res = 1'b1;
    step();
    Res = 1'b0;
    exp_q.delete();
    chk("t5_busy", Busy, 0);
    chk("t5_valid", W_valid, 0);
    chk("t5_addr", Addr_mem_w, 0);
    chk("t5_layer", Layer_idx, 0);
    chk("t5_end", Layer_end, 0);
    step();
    chk("t5_idle", Busy, 0);
    chk("t5_no_done", done_cnt, dsnap);

    // Random backpressure and ack timing.
    for (int p = 0; p < 4; p++) begin
      start_pass(1'($urandom_range(0, 1)));
      run_done(400, 1'b1, dc);
      chk("rnd_done_seen", (dc >= 0) ? 1 : 0, 1);
      step();
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_idle", Busy, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
